stack_pgm_loader: RTL

Writer side of the stack CPU program memory. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, validates each opcode and writes the words into program memory at ascending addresses. The stack CPU is held stopped while a load is in progress. `cpu_run` is asserted only after a complete, error-free load.

---
 rtl/stack_pgm_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_pgm_loader.sv
// Program-memory writer for the stack CPU: byte stream -> validated 16-bit words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module stack_pgm_loader #(
    parameter int INSTR_WIDTH    = 16,
    parameter int PGRM_MEM_DEPTH = 256,
    parameter int PC_WIDTH       = $clog2(PGRM_MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   mem_we,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_run,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [PC_WIDTH:0]      instr_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LEN_HI   = 4'd1,
        S_LEN_LO   = 4'd2,
        S_INSTR_HI = 4'd3,
        S_INSTR_LO = 4'd4,
        S_WRITE    = 4'd5,
        S_DONE     = 4'd6,
        S_ERROR    = 4'd7
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK  = 4'd8
`endif
    } state_t;

    // Highest legal opcode is INVERT; anything above aborts the load.
    localparam logic [4:0]  OP_MAX  = 5'b01000;
    localparam logic [16:0] DEPTH_W = 17'(PGRM_MEM_DEPTH);

    state_t                   state_r, state_s;
    logic [7:0]               len_hi_r, hi_r;
    logic [15:0]              len_r;
    logic [PC_WIDTH-1:0]      addr_r, mem_addr_r;
    logic [PC_WIDTH:0]        count_r, count_inc_s;
    logic [INSTR_WIDTH-1:0]   mem_wdata_r;
    logic                     byte_ready_r, mem_we_r, cpu_run_r, busy_r, done_r, err_r;
    logic                     ready_s, we_s, run_s, busy_s, done_s, err_s;
    logic                     xfer_s, start_ok_s, last_s;
    logic [15:0]              len_s, word_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               csum_r;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign xfer_s      = byte_valid & byte_ready_r;
    assign start_ok_s  = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
    assign len_s       = {len_hi_r, byte_in};
    assign word_s      = {hi_r, byte_in};
    assign count_inc_s = count_r + (PC_WIDTH+1)'(1);
    assign last_s      = (16'(count_inc_s) == len_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok_s) state_s = S_LEN_HI;
                else            state_s = state_r;
            end
            S_LEN_HI: begin
                if (xfer_s) state_s = S_LEN_LO;
                else        state_s = state_r;
            end
            S_LEN_LO: begin
                if (!xfer_s)                                   state_s = state_r;
                else if ((len_s == 16'd0) || ({1'b0, len_s} > DEPTH_W)) state_s = S_ERROR;
                else                                           state_s = S_INSTR_HI;
            end
            S_INSTR_HI: begin
                if (xfer_s) state_s = S_INSTR_LO;
                else        state_s = state_r;
            end
            S_INSTR_LO: begin
                if (!xfer_s)                   state_s = state_r;
                else if (word_s[15:11] > OP_MAX) state_s = S_ERROR;
                else                           state_s = S_WRITE;
            end
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                if (last_s) state_s = S_CHECK;
`else
                if (last_s) state_s = S_DONE;
`endif
                else        state_s = S_INSTR_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (!xfer_s)                 state_s = state_r;
                else if (byte_in == csum_r)  state_s = S_DONE;
                else                         state_s = S_ERROR;
            end
`endif
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs track state_r
    always_comb begin
        ready_s = 1'b0;
        we_s    = 1'b0;
        run_s   = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_s)
            S_LEN_HI, S_LEN_LO, S_INSTR_HI, S_INSTR_LO: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
`endif
            S_WRITE: begin
                we_s   = 1'b1;
                busy_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
                run_s  = 1'b1;
            end
            S_ERROR: begin
                err_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            cpu_run_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            byte_ready_r <= ready_s;
            mem_we_r     <= we_s;
            cpu_run_r    <= run_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    // Length, holding byte, address/count and write-port datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_r    <= 8'd0;
            len_r       <= 16'd0;
            hi_r        <= 8'd0;
            addr_r      <= {PC_WIDTH{1'b0}};
            count_r     <= {(PC_WIDTH+1){1'b0}};
            mem_addr_r  <= {PC_WIDTH{1'b0}};
            mem_wdata_r <= {INSTR_WIDTH{1'b0}};
        end else begin
            if (start_ok_s) begin
                addr_r  <= {PC_WIDTH{1'b0}};
                count_r <= {(PC_WIDTH+1){1'b0}};
            end else if (state_r == S_WRITE) begin
                addr_r  <= addr_r + PC_WIDTH'(1);
                count_r <= count_inc_s;
            end
            if (xfer_s && (state_r == S_LEN_HI))   len_hi_r <= byte_in;
            if (xfer_s && (state_r == S_LEN_LO))   len_r    <= len_s;
            if (xfer_s && (state_r == S_INSTR_HI)) hi_r     <= byte_in;
            if ((state_r == S_INSTR_LO) && (state_s == S_WRITE)) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= word_s;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every streamed byte ahead of the checksum byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= 8'd0;
        end else if (start_ok_s) begin
            csum_r <= 8'd0;
        end else if (xfer_s && (state_r != S_CHECK)) begin
            csum_r <= csum_next(csum_r, byte_in);
        end
    end
`endif

    assign byte_ready  = byte_ready_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign cpu_run     = cpu_run_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign instr_count = count_r;

endmodule
